// File: rtl/nibble_serial_compare_ctrl.sv
// Serial magnitude comparator: one 4-bit compare stage walked MSB->LSB.
// Optional macro EARLY_EXIT_EN stops on the first differing nibble.
module nibble_serial_compare_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_equal_b,
  output logic             a_less_b,
  output logic             a_greater_b
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IW-1:0]    idx;
  logic [3:0]       na, nb;
  logic             decided, dec_lt, dec_gt;
  logic             ne, term, cap, step;
  logic             fin_lt, fin_gt;

  assign a_sh = a_q >> {idx, 2'b00};
  assign b_sh = b_q >> {idx, 2'b00};
  assign na   = a_sh[3:0];
  assign nb   = b_sh[3:0];
  assign ne   = (na != nb);

`ifdef EARLY_EXIT_EN
  assign term = (idx == '0) || ne;
`else
  assign term = (idx == '0);
`endif

  // An earlier decision always wins over the current nibble.
  always_comb begin
    fin_lt = na < nb;
    fin_gt = na > nb;
    if (decided) begin
      fin_lt = dec_lt;
      fin_gt = dec_gt;
    end
  end

  always_comb begin
    state_d = state;
    cap     = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cap     = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        step = 1'b1;
        if (term) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      decided     <= 1'b0;
      dec_lt      <= 1'b0;
      dec_gt      <= 1'b0;
      a_equal_b   <= 1'b0;
      a_less_b    <= 1'b0;
      a_greater_b <= 1'b0;
    end else begin
      state <= state_d;
      if (cap) begin
        a_q     <= a;
        b_q     <= b;
        idx     <= IW'(NIB - 1);
        decided <= 1'b0;
        dec_lt  <= 1'b0;
        dec_gt  <= 1'b0;
      end
      if (step) begin
        if (ne && !decided) begin
          decided <= 1'b1;
          dec_lt  <= na < nb;
          dec_gt  <= na > nb;
        end
        if (term) begin
          a_less_b    <= fin_lt;
          a_greater_b <= fin_gt;
          a_equal_b   <= !fin_lt && !fin_gt;
        end else begin
          idx <= idx - IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
// Directed + swept checks for nibble_serial_compare_ctrl (WIDTH=16).
// Expected latency follows EARLY_EXIT_EN as defined for the build.
module tb_nibble_serial_compare_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic        a_equal_b, a_less_b, a_greater_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2:0] prev_res = 3'b000;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_LT = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

`ifdef EARLY_EXIT_EN
  localparam int EE = 1;
`else
  localparam int EE = 0;
`endif

  nibble_serial_compare_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_equal_b   (a_equal_b),
    .a_less_b    (a_less_b),
    .a_greater_b (a_greater_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] res();
    return {a_equal_b, a_less_b, a_greater_b};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_m(input logic [15:0] x, input logic [15:0] y);
    if (EE == 0) return 4;
    for (int k = 1; k <= 4; k++) begin
      if (x[16-4*k +: 4] != y[16-4*k +: 4]) return k;
    end
    return 4;
  endfunction

  function automatic logic [2:0] model_res(input logic [15:0] x,
                                           input logic [15:0] y);
    if (x == y) return R_EQ;
    if (x < y)  return R_LT;
    return R_GT;
  endfunction

  task automatic wait_done(input string tag, input logic hold_chk,
                           output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (hold_chk) check({tag, "_hold"}, res(), prev_res);
      a = 16'($urandom);
      b = 16'($urandom);
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic run(input string tag, input logic [15:0] ta,
                     input logic [15:0] tb_, input logic [2:0] exp_res,
                     input int exp_m, input logic hold_chk);
    int n;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta;
    b = ~tb_;
    wait_done(tag, hold_chk, n);
    check({tag, "_lat"}, n, exp_m);
    check({tag, "_res"}, res(), exp_res);
    check({tag, "_busy"}, busy, 1'b1);
    @(posedge clk); #1;
    check({tag, "_donefall"}, done, 1'b0);
    check({tag, "_busyfall"}, busy, 1'b0);
    check({tag, "_keep"}, res(), exp_res);
    prev_res = exp_res;
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    int u;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", res(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    run("eq", 16'h1234, 16'h1234, R_EQ, 4, 1'b1);
    run("gt_msb", 16'h8000, 16'h7FFF, R_GT, (EE != 0) ? 1 : 4, 1'b1);
    run("lt_lsb", 16'h1230, 16'h1231, R_LT, 4, 1'b1);
    run("b2b_gt", 16'hFFFF, 16'h0000, R_GT, (EE != 0) ? 1 : 4, 1'b1);
    run("gt_n2", 16'h1534, 16'h1434, R_GT, (EE != 0) ? 2 : 4, 1'b1);
    run("lt_n3", 16'hAB1F, 16'hAB2E, R_LT, (EE != 0) ? 3 : 4, 1'b1);

    // start held high while operands churn
    @(negedge clk);
    start = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    @(posedge clk); #1;
    check("hold_busy0", busy, 1'b1);
    wait_done("hold", 1'b0, n);
    check("hold_lat", n, (EE != 0) ? 1 : 4);
    check("hold_res", res(), R_LT);
    @(negedge clk);
    a = 16'h9999;
    b = 16'h0001;
    @(posedge clk); #1;
    check("hold_idle", busy, 1'b0);
    check("hold_nodone", done, 1'b0);
    @(negedge clk);
    a = 16'h5555;
    b = 16'h5555;
    @(posedge clk); #1;
    check("hold_restart", busy, 1'b1);
    start = 1'b0;
    wait_done("hold2", 1'b0, n);
    check("hold2_res", res(), R_EQ);
    @(posedge clk); #1;
    check("hold2_idle", busy, 1'b0);
    prev_res = R_EQ;

    // async reset mid-compare
    @(negedge clk);
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFE;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_res", res(), 3'b000);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("arst_nodone", done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_res = 3'b000;
    run("post_rst", 16'h0001, 16'h0002, R_LT, 4, 1'b1);

    // sweep with forced equal upper nibbles
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      u = $urandom_range(0, 4);
      for (int k = 0; k < u; k++) rb[15-4*k -: 4] = ra[15-4*k -: 4];
      run("sweep", ra, rb, model_res(ra, rb), model_m(ra, rb), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_compare_ctrl.md
Name: nibble_serial_compare_ctrl

Overview:
Sequencer that compares two WIDTH-bit unsigned operands by stepping one shared 4-bit magnitude compare stage across the operands, one nibble per clock, starting at the MSB nibble. It captures operands on a start handshake, runs the nibble loop and reports equal/less/greater with a one-cycle done pulse. It is used where a full-width comparator is too costly and a multi-cycle latency is acceptable.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; elaboration fails otherwise.
NIB, WIDTH/4, derived number of nibbles; not overridable.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a comparison; accepted only when busy=0.
a  input  WIDTH  operand A, sampled on the accepting edge only.
b  input  WIDTH  operand B, sampled on the accepting edge only.
busy  output  1  high while a comparison is in progress, including the done cycle.
done  output  1  one-cycle pulse; results are valid from this cycle onward.
a_equal_b  output  1  registered result.
a_less_b  output  1  registered result.
a_greater_b  output  1  registered result.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done and all three result outputs = 0; operand regs, nibble index and decided flag cleared. Reset mid-comparison aborts it with no done pulse.
- States: IDLE, COMPARE, DONE.
- IDLE: start=1 at edge E0 captures a/b, sets idx=NIB-1, clears decided, goes to COMPARE. Result outputs keep their previous values until the next done.
- COMPARE, edge Ek (k=1..NIB): compare nibble idx of A against B. If the nibble is unequal and decided=0, latch lt/gt into internal result regs and set decided=1. Termination depends on EARLY_EXIT_EN (see below). If the loop does not terminate, idx decrements.
- When idx=0 and the nibble is compared, the loop terminates. If decided is still 0, the result is equal.
- On the terminating edge: move to DONE and drive the result outputs. Exactly one of a_equal_b/a_less_b/a_greater_b is 1.
- DONE: done=1 for exactly one cycle. The next edge returns the block to IDLE.
- busy=1 in COMPARE and DONE. start while busy=1, including in the DONE cycle, is ignored and not queued.
- Latency: from the E0 edge until done is high is m edges, where m is the number of nibbles evaluated (1..NIB). The back-to-back issue interval is m+2 cycles.
- The first differing nibble from the MSB decides the result. Lower nibbles never override it.
- Changes on a/b after E0 have no effect on an in-flight comparison.

Optional Feature:
Macro EARLY_EXIT_EN.
- Defined: COMPARE terminates on the first unequal nibble, so m is the index of the first differing nibble from the MSB (1..NIB), or NIB for equal operands.
- Undefined: always m=NIB, giving constant latency. The result is still taken from the first differing nibble, held by the decided flag.

Test Plan:
- WIDTH=16, a=0x1234, b=0x1234, start pulse -> after 4 compare edges, done=1 for one cycle, a_equal_b=1, others 0, busy falls the cycle after done (both macro settings).
- a=0x8000, b=0x7FFF -> a_greater_b=1. With EARLY_EXIT_EN, done rises after 1 compare edge. Without the macro, done rises after 4 compare edges and the result is still greater (lower nibbles 0 vs F do not override).
- a=0x1230, b=0x1231 -> a_less_b=1, done after 4 compare edges in both builds. Then a=0xFFFF, b=0x0000 issued back-to-back -> a_greater_b=1, and the previous result holds until the new done.
- Start held high through the whole operation with a/b changing every cycle -> exactly one comparison of the E0 operands. A second comparison begins only at the first edge where busy=0, i.e. in IDLE.
- rst_n driven low asynchronously mid-COMPARE -> outputs go to 0 immediately without waiting for a clock edge, and no done pulse occurs. After release, start with a=0x0001, b=0x0002 -> a_less_b=1.
- Randomized sweep, ≥1000 operand pairs with forced equal upper nibbles -> results match A==B / A<B / A>B, and latency matches m for the build's macro setting.
